// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func                        |
// | Description : Power-switch sequencer for a gated standard-cell row region.  |
// |               Staggers the header-switch segment enables on and off, one    |
// |               segment every STEP clocks, and acknowledges only once every   |
// |               segment is on and settled.                                    |
// |               Optional macro GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN adds the |
// |               ISO isolation-clamp request output.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func #(
  parameter int SEGS = 4,   // header-switch segments, 1..16
  parameter int STEP = 8    // clocks between segment transitions, 1..255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  output logic [SEGS-1:0] EN,
  output logic            ACK
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN
  ,
  output logic            ISO
`endif
);

  // Level register spans 0..SEGS; step counter spans 0..STEP-1.
  localparam int LW = $clog2(SEGS + 1);
  localparam int CW = $clog2(STEP + 1);

  localparam logic [LW-1:0] c_lvl_max = LW'(SEGS);
  localparam logic [LW-1:0] c_lvl_one = LW'(1);
  localparam logic [CW-1:0] c_cnt_rld = CW'(STEP - 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_RAMP_UP = 2'd1,
    S_ON      = 2'd2,
    S_RAMP_DN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lvl;
  logic [LW-1:0]   w_lvl_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  // State, level and step-counter registers; reset drops every segment at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_OFF;
      r_lvl   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lvl   <= w_lvl_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a REQ reversal takes priority over a counter step, and
  // a reversal keeps the current level so EN never jumps.
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_OFF: begin
        if (REQ) begin
          w_state_nxt = S_RAMP_UP;
          w_lvl_nxt   = c_lvl_one;
          w_cnt_nxt   = c_cnt_rld;
        end
      end
      S_RAMP_UP: begin
        if (!REQ) begin
          w_state_nxt = S_RAMP_DN;
          w_cnt_nxt   = c_cnt_rld;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end else if (r_lvl < c_lvl_max) begin
          w_lvl_nxt = r_lvl + c_lvl_one;
          w_cnt_nxt = c_cnt_rld;
        end else begin
          w_state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (!REQ) begin
          w_state_nxt = S_RAMP_DN;
          w_cnt_nxt   = c_cnt_rld;
        end
      end
      S_RAMP_DN: begin
        if (REQ) begin
          w_state_nxt = S_RAMP_UP;
          w_cnt_nxt   = c_cnt_rld;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end else begin
          w_lvl_nxt = r_lvl - c_lvl_one;
          w_cnt_nxt = c_cnt_rld;
          // Dropping the last segment lands directly in OFF.
          if (r_lvl == c_lvl_one) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_lvl_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Thermometer decode of the level: EN = (1 << LVL) - 1.
  for (genvar i = 0; i < SEGS; i++) begin : g_en
    assign EN[i] = (r_lvl > LW'(i));
  end

  assign ACK = (r_state == S_ON);

`ifdef GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN
  logic r_iso;

  // Isolation releases one edge after ACK rises and re-clamps on the edge ACK
  // falls, so the clamp is in place before any segment is switched off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_iso <= 1'b1;
    end else begin
      r_iso <= !((r_state == S_ON) && REQ);
    end
  end

  assign ISO = r_iso;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func                     |
// | Description : Scoreboard bench for the power-switch sequencer, SEGS=4,      |
// |               STEP=3. Stimulus pushes hand-computed per-edge expectations; |
// |               a monitor pops and compares after every rising edge.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func;

  localparam int SEGS = 4;
  localparam int STEP = 3;

  logic            clk;
  logic            rst;
  logic            req;
  logic [SEGS-1:0] en;
  logic            ack;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN
  logic            iso;
`endif

  typedef struct {
    logic [SEGS-1:0] en;
    logic            ack;
    logic            iso;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func #(
    .SEGS(SEGS),
    .STEP(STEP)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .REQ(req),
    .EN (en),
    .ACK(ack)
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN
    ,
    .ISO(iso)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n edges with the given inputs; each edge gets one expectation.
  task automatic rep(input int n, input logic r, input logic q,
                     input logic [SEGS-1:0] e_en, input logic e_ack,
                     input logic e_iso, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r;
      req = q;
      e.en  = e_en;
      e.ack = e_ack;
      e.iso = e_iso;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every rising edge yields one output sample to score.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (en !== e.en) begin
          n_fail++;
          $display("FAIL %s EN: got %b expected %b at %0t", e.tag, en, e.en, $time);
        end
        n_tests++;
        if (ack !== e.ack) begin
          n_fail++;
          $display("FAIL %s ACK: got %b expected %b at %0t", e.tag, ack, e.ack, $time);
        end
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN
        n_tests++;
        if (iso !== e.iso) begin
          n_fail++;
          $display("FAIL %s ISO: got %b expected %b at %0t", e.tag, iso, e.iso, $time);
        end
`endif
      end
    end
  end

  // Stimulus with hand-derived per-edge expectations.
  initial begin
    rst = 1'b1;
    req = 1'b1;

    // Reset with REQ held high: nothing powers up.
    rep(2, 1, 1, 4'b0000, 0, 1, "reset");
    // Release at edge 0 with REQ=1: one segment every 3 edges, ACK at 12, ISO off at 13.
    rep(3, 0, 1, 4'b0001, 0, 1, "up_l1");
    rep(3, 0, 1, 4'b0011, 0, 1, "up_l2");
    rep(3, 0, 1, 4'b0111, 0, 1, "up_l3");
    rep(3, 0, 1, 4'b1111, 0, 1, "up_l4");
    rep(1, 0, 1, 4'b1111, 1, 1, "up_ack");
    rep(2, 0, 1, 4'b1111, 1, 0, "on");

    // Power-down from ON: ACK falls and ISO clamps at edge 0, OFF at 12.
    rep(3, 0, 0, 4'b1111, 0, 1, "dn_l4");
    rep(3, 0, 0, 4'b0111, 0, 1, "dn_l3");
    rep(3, 0, 0, 4'b0011, 0, 1, "dn_l2");
    rep(3, 0, 0, 4'b0001, 0, 1, "dn_l1");
    rep(2, 0, 0, 4'b0000, 0, 1, "off_hold");

    // Ramp-up reversal: REQ drops at edge 4 with EN=0011.
    rep(3, 0, 1, 4'b0001, 0, 1, "rvu_l1");
    rep(1, 0, 1, 4'b0011, 0, 1, "rvu_l2");
    rep(3, 0, 0, 4'b0011, 0, 1, "rvu_hold");
    rep(3, 0, 0, 4'b0001, 0, 1, "rvu_dn1");
    rep(2, 0, 0, 4'b0000, 0, 1, "rvu_off");

    // Bring the region up to ON again.
    rep(3, 0, 1, 4'b0001, 0, 1, "up2_l1");
    rep(3, 0, 1, 4'b0011, 0, 1, "up2_l2");
    rep(3, 0, 1, 4'b0111, 0, 1, "up2_l3");
    rep(3, 0, 1, 4'b1111, 0, 1, "up2_l4");
    rep(1, 0, 1, 4'b1111, 1, 1, "up2_ack");
    rep(1, 0, 1, 4'b1111, 1, 0, "on2");

    // Ramp-down reversal: REQ=0 at edge 0, REQ=1 again at edge 4 (EN=0111).
    rep(3, 0, 0, 4'b1111, 0, 1, "rvd_l4");
    rep(1, 0, 0, 4'b0111, 0, 1, "rvd_l3");
    rep(3, 0, 1, 4'b0111, 0, 1, "rvd_hold");
    rep(3, 0, 1, 4'b1111, 0, 1, "rvd_l4b");
    rep(1, 0, 1, 4'b1111, 1, 1, "rvd_ack");
    rep(1, 0, 1, 4'b1111, 1, 0, "rvd_on");

    // Reset straight out of ON, then reset again mid ramp-up at edge 5.
    rep(1, 1, 1, 4'b0000, 0, 1, "rst_on");
    rep(3, 0, 1, 4'b0001, 0, 1, "mr_l1");
    rep(2, 0, 1, 4'b0011, 0, 1, "mr_l2");
    rep(1, 1, 1, 4'b0000, 0, 1, "mr_rst");
    rep(3, 0, 1, 4'b0001, 0, 1, "mr_restart");
    rep(1, 0, 1, 4'b0011, 0, 1, "mr_l2b");
    rep(1, 1, 0, 4'b0000, 0, 1, "final_rst");

    // Let the monitor drain, then confirm every expectation was scored.
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func.md
# gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq_func

Behavioural model of the power-switch sequencer for a gated standard-cell row region. The region's row boundaries are terminated by endcap cells. The sequencer drives the header-switch segment enables that feed the gated rows. It staggers the segments on and off to limit inrush current, and it raises an acknowledge only when every segment has settled.

## Interface
Parameters:
- SEGS, 4, number of header-switch segments; legal range 1..16.
- STEP, 8, CLK cycles between consecutive segment transitions and before ACK; legal range 1..255.

Ports:
- CLK  input  1  sequencer clock; all state changes occur on its rising edge.
- RST  input  1  reset, synchronous and active-high.
- REQ  input  1  power request level: 1 = power region on, 0 = power region off.
- EN  output  SEGS  segment enables in thermometer code; EN[0] is the first segment on and the last segment off.
- ACK  output  1  1 only while all segments are enabled and settled (state ON).
- ISO  output  1  isolation clamp request (present only with the configuration macro).

## Operation
- States: OFF, RAMP_UP, ON, RAMP_DN. Step counter CNT is $clog2(STEP+1) bits wide. Level register LVL holds 0..SEGS. EN = (1<<LVL)-1.
- Reset (RST=1 at an edge), regardless of current state: state=OFF, LVL=0, CNT=0. Outputs: EN=0, ACK=0, ISO=1. Reset mid-ramp drops all segments in the same cycle.
- OFF:
  - REQ=1 → RAMP_UP; LVL=1; CNT=STEP-1.
  - REQ=0 → hold.
- RAMP_UP:
  - CNT≠0 → decrement CNT.
  - CNT=0 and LVL<SEGS → LVL+1; CNT=STEP-1.
  - CNT=0 and LVL=SEGS → ON.
  - REQ=0 at any cycle → RAMP_DN; CNT=STEP-1; LVL unchanged (reversal).
- ON: ACK=1.
  - REQ=0 → RAMP_DN; CNT=STEP-1; ACK=0 on the same edge.
- RAMP_DN:
  - CNT≠0 → decrement CNT.
  - CNT=0 → LVL-1; CNT=STEP-1.
  - A transition that makes LVL reach 0 also enters OFF on the same edge.
  - REQ=1 at any cycle → RAMP_UP; CNT=STEP-1; LVL unchanged.
- Priority: RST over REQ reversal, and REQ reversal over a counter step in the same cycle.
- EN changes by at most one bit per edge. EN never skips a level.

## Timing
- REQ is sampled at rising edges; latency is measured from the sampling edge k.
- Power-up, from OFF:
  - EN bit i (0-based) rises at edge k+i·STEP.
  - ACK rises at edge k+SEGS·STEP.
- Power-down, from ON:
  - ACK falls at edge k.
  - EN bit SEGS-1-i falls at edge k+(i+1)·STEP.
  - OFF is reached at edge k+SEGS·STEP.
- Reversal at edge k: the next level change occurs at edge k+STEP.
- STEP=1: one level change per cycle; ACK follows the last EN bit by one cycle.
- REQ pulses shorter than one cycle between edges are invisible.

## Configuration
- Macro GF180MCU_FD_SC_MCU9T5V0__PWRSW_ISO_EN.
- Defined: ISO port exists.
  - ISO=1 in reset and OFF.
  - ISO falls one edge after ACK rises (edge k+SEGS·STEP+1).
  - ISO rises on the same edge ACK falls, i.e. before any segment drops.
  - ISO rises on reset.
- Undefined: no ISO port and no ISO register; all other behaviour is identical.

## Test plan
All scenarios use SEGS=4, STEP=3.
- Reset with REQ=1 held → EN=0000 and ACK=0 while RST=1. After release at edge 0 (REQ still 1): EN=0001@0, 0011@3, 0111@6, 1111@9; ACK=1@12.
- From ON, REQ=0 sampled @0 → ACK=0@0; EN=0111@3, 0011@6, 0001@9, 0000@12; state OFF@12.
- Ramp-up reversal: REQ=1@0, REQ=0 sampled @4 (EN=0011) → EN=0001@7, 0000@10; ACK stays 0 throughout.
- Ramp-down reversal: from ON, REQ=0@0, REQ=1 sampled @4 (EN=0111) → EN=1111@7; ACK=1@10.
- RST=1 asserted @5 during ramp-up → EN=0000 and ACK=0 @5. With REQ=1 after release, the ramp restarts at EN=0001.
- With the ISO macro, power-up then power-down → ISO=1 until edge 13, 0 from edge 13. ISO rises at the REQ=0 sampling edge, the same edge ACK falls. Without the macro, the bench compiles with no ISO port.
